// File: rtl/fifo_pkt_pkg.sv
// Shared types and constants for the FIFO packet framer.
package fifo_pkt_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_HEADER,
    S_PAYLOAD,
    S_TRAILER
  } state_t;

  localparam logic [7:0] DEFAULT_HEADER = 8'hA5;
  localparam int         PKT_COUNT_W    = 16;

endpackage

// File: rtl/framer_skid_buf.sv
// Two-entry skid buffer between the FIFO read data and the output stream.
// The head entry is held in a register so the stream data never depends on fifo_data.
module framer_skid_buf #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [1:0]            occ,
  output logic [DATA_WIDTH-1:0] head_data
);

  logic [DATA_WIDTH-1:0] tail_data;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      occ       <= 2'd0;
      head_data <= '0;
      tail_data <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (occ == 2'd0) head_data <= push_data;
          else             tail_data <= push_data;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          head_data <= tail_data;
          occ       <= occ - 2'd1;
        end
        2'b11: begin
          // Simultaneous push/pop keeps occupancy; the new word lands behind any survivor.
          if (occ == 2'd1) begin
            head_data <= push_data;
          end else begin
            head_data <= tail_data;
            tail_data <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fifo_pkt_framer.sv
// Frames FIFO payload words into header + PKT_LEN payload (+ checksum trailer) packets.
// Define FRAMER_CHECKSUM_EN to build the TRAILER state and checksum accumulator.
module fifo_pkt_framer
  import fifo_pkt_pkg::*;
#(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    PKT_LEN    = 4,
  parameter logic [DATA_WIDTH-1:0] HEADER     = DATA_WIDTH'(DEFAULT_HEADER)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   fifo_empty,
  output logic                   fifo_rd_en,
  input  logic [DATA_WIDTH-1:0]  fifo_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [DATA_WIDTH-1:0]  m_data,
  output logic                   m_sop,
  output logic                   m_eop,
  output logic [PKT_COUNT_W-1:0] pkt_count
);

  localparam int               CNT_W    = $clog2(PKT_LEN + 1);
  localparam logic [CNT_W-1:0] LEN      = CNT_W'(PKT_LEN);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(PKT_LEN - 1);

  state_t                  state_reg;
  logic [CNT_W-1:0]        issued_reg;
  logic [CNT_W-1:0]        paid_reg;
  logic                    inflight_reg;
  logic [PKT_COUNT_W-1:0]  pkt_count_reg;
  logic [1:0]              occ;
  logic [DATA_WIDTH-1:0]   head_data;
  logic                    hs;
  logic                    pop;
  logic [2:0]              pending;

  framer_skid_buf #(.DATA_WIDTH(DATA_WIDTH)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight_reg),
    .push_data (fifo_data),
    .pop       (pop),
    .occ       (occ),
    .head_data (head_data)
  );

  assign hs      = m_valid & m_ready;
  assign pop     = hs && (state_reg == S_PAYLOAD);
  // Words already committed to the skid buffer once this cycle's pop is taken out.
  assign pending = {1'b0, occ} + {2'b00, inflight_reg} - {2'b00, pop};
  assign fifo_rd_en = ((state_reg == S_HEADER) || (state_reg == S_PAYLOAD)) &&
                      !fifo_empty && (issued_reg < LEN) && (pending < 3'd2);
  assign pkt_count  = pkt_count_reg;

`ifdef FRAMER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] csum_reg;

  always_ff @(posedge clk) begin
    if (!rst_n)                     csum_reg <= '0;
    else if (state_reg == S_HEADER) csum_reg <= '0;
    else if (pop)                   csum_reg <= csum_reg + head_data;
  end
`endif

  always_comb begin
    m_valid = 1'b0;
    m_data  = '0;
    m_sop   = 1'b0;
    m_eop   = 1'b0;
    case (state_reg)
      S_HEADER: begin
        m_valid = 1'b1;
        m_data  = HEADER;
        m_sop   = 1'b1;
      end
      S_PAYLOAD: begin
        m_valid = (occ != 2'd0);
        m_data  = head_data;
`ifndef FRAMER_CHECKSUM_EN
        m_eop   = (occ != 2'd0) && (paid_reg == LAST_IDX);
`endif
      end
`ifdef FRAMER_CHECKSUM_EN
      S_TRAILER: begin
        m_valid = 1'b1;
        m_data  = csum_reg;
        m_eop   = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= S_IDLE;
      issued_reg    <= '0;
      paid_reg      <= '0;
      inflight_reg  <= 1'b0;
      pkt_count_reg <= '0;
    end else begin
      inflight_reg <= fifo_rd_en;
      if (fifo_rd_en) issued_reg <= issued_reg + 1'b1;
      if (hs && m_eop) pkt_count_reg <= pkt_count_reg + 1'b1;
      case (state_reg)
        S_IDLE: begin
          if (!fifo_empty) begin
            state_reg  <= S_HEADER;
            issued_reg <= '0;
          end
        end
        S_HEADER: if (hs) state_reg <= S_PAYLOAD;
        S_PAYLOAD: begin
          if (pop) begin
            if (paid_reg == LAST_IDX) begin
              paid_reg <= '0;
`ifdef FRAMER_CHECKSUM_EN
              state_reg <= S_TRAILER;
`else
              state_reg <= S_IDLE;
`endif
            end else begin
              paid_reg <= paid_reg + 1'b1;
            end
          end
        end
        S_TRAILER: if (hs) state_reg <= S_IDLE;
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_pkt_framer.sv
// Scoreboard bench for fifo_pkt_framer with a behavioural FIFO and a packet-level reference model.
// Expected trailer presence follows FRAMER_CHECKSUM_EN, as in the design.
module tb_fifo_pkt_framer;

  localparam int         DW  = 8;
  localparam int         PL  = 4;
  localparam logic [7:0] HDR = 8'hA5;

  logic        clk        = 1'b0;
  logic        rst_n      = 1'b0;
  logic        fifo_empty = 1'b1;
  logic        fifo_rd_en;
  logic [7:0]  fifo_data  = 8'h00;
  logic        m_valid;
  logic        m_ready    = 1'b0;
  logic [7:0]  m_data;
  logic        m_sop;
  logic        m_eop;
  logic [15:0] pkt_count;

  always #5 clk = ~clk;

  fifo_pkt_framer #(.DATA_WIDTH(DW), .PKT_LEN(PL), .HEADER(HDR)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .fifo_data  (fifo_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_sop      (m_sop),
    .m_eop      (m_eop),
    .pkt_count  (pkt_count)
  );

  typedef struct packed {
    logic [7:0] d;
    logic       sop;
    logic       eop;
    logic       pay;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] src_mem [0:4095];
  int         src_wr     = 0;
  int         src_rd     = 0;
  int         checks     = 0;
  int         errors     = 0;
  int         pay_seen   = 0;
  int         ready_mode = 0;

  // Behavioural FIFO: registered data_out, empty flag updated at the clock edge.
  always @(posedge clk) begin
    if (!rst_n) begin
      src_rd = src_wr;
    end else if (fifo_rd_en && !fifo_empty) begin
      fifo_data <= src_mem[src_rd];
      src_rd++;
    end
    fifo_empty <= (src_rd >= src_wr);
  end

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       m_ready = 1'b1;
      1:       m_ready = ~m_ready;
      default: m_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: pops the scoreboard on every handshake and checks stream properties.
  logic       rst_q = 1'b0;
  int         exp_pkt = 0;
  int         held = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_d = 8'h00;
  logic       prev_sop = 1'b0;
  logic       prev_eop = 1'b0;

  always @(posedge clk) rst_q <= !rst_n;

  always @(negedge clk) begin
    exp_t e;
    logic hs_now, rd_now, pop_now;
    if (rst_q) begin
      checks++;
      if (fifo_rd_en !== 1'b0 || m_valid !== 1'b0 || m_sop !== 1'b0 || m_eop !== 1'b0 ||
          m_data !== 8'h00 || pkt_count !== 16'h0000) begin
        errors++;
        $display("FAIL reset_state: got rd_en=%b valid=%b sop=%b eop=%b data=%h cnt=%0d, need all 0",
                 fifo_rd_en, m_valid, m_sop, m_eop, m_data, pkt_count);
      end
      exp_pkt    = 0;
      held       = 0;
      prev_stall = 1'b0;
    end else begin
      checks++;
      if (pkt_count !== 16'(exp_pkt)) begin
        errors++;
        $display("FAIL pkt_count: got %0d, need %0d", pkt_count, 16'(exp_pkt));
      end
      if (prev_stall) begin
        checks++;
        if (m_valid !== 1'b1 || m_data !== prev_d || m_sop !== prev_sop || m_eop !== prev_eop) begin
          errors++;
          $display("FAIL stall_hold: got valid=%b data=%h sop=%b eop=%b, need valid=1 data=%h sop=%b eop=%b",
                   m_valid, m_data, m_sop, m_eop, prev_d, prev_sop, prev_eop);
        end
      end
      hs_now  = m_valid && m_ready && rst_n;
      pop_now = 1'b0;
      if (hs_now) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_word: got data=%h sop=%b eop=%b, need no word", m_data, m_sop, m_eop);
        end else begin
          e = exp_q.pop_front();
          if (m_data !== e.d || m_sop !== e.sop || m_eop !== e.eop) begin
            errors++;
            $display("FAIL stream_word: got data=%h sop=%b eop=%b, need data=%h sop=%b eop=%b",
                     m_data, m_sop, m_eop, e.d, e.sop, e.eop);
          end
          pop_now = e.pay;
          if (e.pay) pay_seen++;
          if (e.eop) exp_pkt = (exp_pkt + 1) % 65536;
        end
      end
      rd_now = fifo_rd_en && !fifo_empty && rst_n;
      if (rd_now) begin
        checks++;
        if (held + 1 - int'(pop_now) > 2) begin
          errors++;
          $display("FAIL read_overrun: got %0d words held after read, need at most 2",
                   held + 1 - int'(pop_now));
        end
      end
      held       = held + int'(rd_now) - int'(pop_now);
      prev_stall = m_valid && !m_ready && rst_n;
      prev_d     = m_data;
      prev_sop   = m_sop;
      prev_eop   = m_eop;
    end
  end

  // Reference model: a packet is the header, its payload, then the mod-256 sum when built with a trailer.
  task automatic expect_pkt(input logic [PL*8-1:0] words);
`ifdef FRAMER_CHECKSUM_EN
    int sum;
    sum = 0;
`endif
    exp_q.push_back('{d: HDR, sop: 1'b1, eop: 1'b0, pay: 1'b0});
    for (int i = 0; i < PL; i++) begin
`ifdef FRAMER_CHECKSUM_EN
      sum = sum + int'(words[i*8 +: 8]);
      exp_q.push_back('{d: words[i*8 +: 8], sop: 1'b0, eop: 1'b0, pay: 1'b1});
`else
      exp_q.push_back('{d: words[i*8 +: 8], sop: 1'b0, eop: (i == PL - 1), pay: 1'b1});
`endif
    end
`ifdef FRAMER_CHECKSUM_EN
    exp_q.push_back('{d: 8'(sum % 256), sop: 1'b0, eop: 1'b1, pay: 1'b0});
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [7:0] w);
    src_mem[src_wr % 4096] = w;
    src_wr++;
  endtask

  task automatic send_pkt(input logic [PL*8-1:0] words);
    expect_pkt(words);
    for (int i = 0; i < PL; i++) push_word(words[i*8 +: 8]);
  endtask

  task automatic wait_drain(input int limit);
    for (int i = 0; i < limit && exp_q.size() != 0; i++) tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d words outstanding, need 0", exp_q.size());
    end
    repeat (3) tick();
  endtask

  function automatic logic [PL*8-1:0] rand_words();
    logic [PL*8-1:0] w;
    for (int i = 0; i < PL; i++) w[i*8 +: 8] = 8'($urandom);
    return w;
  endfunction

  logic [PL*8-1:0] words;
  int              base;

  initial begin
    rst_n      = 1'b0;
    ready_mode = 0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    send_pkt({8'h04, 8'h03, 8'h02, 8'h01});
    wait_drain(200);

    send_pkt({8'h03, 8'hFF, 8'hFF, 8'hFF});
    wait_drain(200);

    ready_mode = 1;
    repeat (3) send_pkt(rand_words());
    wait_drain(400);
    ready_mode = 0;

    // FIFO runs dry halfway through a packet.
    words = rand_words();
    expect_pkt(words);
    push_word(words[7:0]);
    push_word(words[15:8]);
    repeat (8) tick();
    push_word(words[23:16]);
    push_word(words[31:24]);
    wait_drain(200);

    // Reset after the second payload word of a packet.
    base = pay_seen;
    send_pkt(rand_words());
    for (int i = 0; i < 200 && pay_seen < base + 2; i++) tick();
    checks++;
    if (pay_seen < base + 2) begin
      errors++;
      $display("FAIL reset_wait_timeout: got %0d payload words, need %0d", pay_seen - base, 2);
    end
    rst_n = 1'b0;
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    repeat (2) tick();
    send_pkt(rand_words());
    wait_drain(200);

    ready_mode = 2;
    for (int p = 0; p < 15; p++) begin
      words = rand_words();
      expect_pkt(words);
      for (int i = 0; i < PL; i++) begin
        push_word(words[i*8 +: 8]);
        repeat ($urandom_range(0, 2)) tick();
      end
    end
    wait_drain(2000);
    ready_mode = 0;
    repeat (4) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_pkt_framer.md
# fifo_pkt_framer

Downstream consumer of the team's synchronous FIFO. It pulls payload words through the FIFO's read port (r_en / empty / registered data_out) and emits fixed-length framed packets on a valid/ready stream: a header word, PKT_LEN payload words, and optionally a checksum trailer. It sits between the FIFO and the link/serializer stage and decouples FIFO read latency from output backpressure with a 2-entry skid buffer.

## Interface
- DATA_WIDTH, 8, width of FIFO data and stream data
- PKT_LEN, 4, payload words per packet (≥1)
- HEADER, 8'hA5, constant header word (DATA_WIDTH bits)
- clk  input  1  clock
- rst_n  input  1  reset, synchronous, active-low
- fifo_empty  input  1  FIFO empty flag
- fifo_rd_en  output  1  FIFO read request
- fifo_data  input  DATA_WIDTH  FIFO data_out, valid the cycle after an accepted read
- m_valid  output  1  stream word valid
- m_ready  input  1  downstream accept
- m_data  output  DATA_WIDTH  stream word
- m_sop  output  1  first word of packet (header)
- m_eop  output  1  last word of packet
- pkt_count  output  16  completed packets, wraps at 2^16

## Operation
- FSM states: IDLE, HEADER, PAYLOAD, TRAILER.
- IDLE: if !fifo_empty -> HEADER next cycle.
- HEADER: m_valid=1, m_data=HEADER, m_sop=1; on m_valid&m_ready -> PAYLOAD.
- Read issue (HEADER and PAYLOAD): fifo_rd_en = !fifo_empty && issued < PKT_LEN && (occ + inflight − pop) < 2; occ = skid entries, inflight = read issued last cycle, pop = handshake on a payload word this cycle. issued counts reads for current packet, cleared on entry to HEADER.
- Skid buffer captures fifo_data in the cycle after an issued read; never overflows; m_valid in PAYLOAD = occ≠0, m_data = head entry.
- PAYLOAD: count payload handshakes; on the PKT_LEN-th -> TRAILER (checksum build) or IDLE (no checksum, m_eop=1 on that word).
- TRAILER: m_valid=1, m_data=checksum, m_eop=1; on handshake -> IDLE.
- Checksum: sum of payload words modulo 2^DATA_WIDTH, accumulated on payload handshakes, cleared in HEADER.
- pkt_count increments on every m_eop handshake; wraps 16'hFFFF -> 0.
- m_data/m_sop/m_eop hold stable while m_valid && !m_ready.
- PKT_LEN=1: single payload word, issued limit 1.

## Timing
- Reset: state IDLE, fifo_rd_en=0, m_valid=0, m_data=0, m_sop=0, m_eop=0, pkt_count=0, skid emptied, checksum=0, counters 0.
- Reset mid-packet: packet abandoned, in-flight/buffered words discarded, no eop emitted; FIFO shares rst_n.
- IDLE->HEADER: 1 cycle after fifo_empty seen low.
- First payload word valid 2 cycles after header's first valid cycle (read in HEADER, FIFO register, skid capture).
- Steady state with m_ready=1 and FIFO non-empty: 1 payload word/cycle.
- m_ready low: at most 2 words buffered, fifo_rd_en deasserts; resumes with no loss/duplication.
- FIFO goes empty mid-packet: m_valid drops after buffer drains; packet continues when data returns.

## Configuration
- FRAMER_CHECKSUM_EN defined: TRAILER state and checksum accumulator compiled in; packet = PKT_LEN+2 words, eop on trailer.
- Not defined: no TRAILER, no accumulator; packet = PKT_LEN+1 words, eop on last payload word.

## Structure
- Package fifo_pkt_pkg: state enum typedef (IDLE/HEADER/PAYLOAD/TRAILER), default HEADER constant, pkt_count width constant.
- Sub-module framer_skid_buf: 2-entry buffer with push, pop, occ output, registered head data.

## Test plan
- PKT_LEN=4, FIFO holds 01 02 03 04, m_ready=1, checksum on -> stream A5(sop) 01 02 03 04 0A(eop); pkt_count=1.
- Same, checksum off -> A5(sop) 01 02 03 04(eop); no trailer cycle.
- Payload FF FF FF 03 -> trailer 00 (mod-256 wrap).
- m_ready toggled 1/0 every cycle over 3 packets -> no dropped/duplicated words, fifo_rd_en never asserted with occ+inflight−pop ≥ 2, data held while stalled.
- FIFO supplies 2 words then empty for 5 cycles then 2 more -> m_valid gap, packet completes correctly.
- rst_n low for 1 cycle after payload word 2 -> all outputs 0, state IDLE, pkt_count=0; next packet framed from A5.
